// File: rtl/dram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dram_pkg                                                  |
// | Purpose  : Shared types, default timings and helpers for the DRAM    |
// |            RAS/CAS sequencer.                                        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package dram_pkg;

   // Sequencer states; encoding width is explicit so the register is 3 bits.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RAS  = 3'd1,
      ST_MUX  = 3'd2,
      ST_CAS  = 3'd3,
      ST_HOLD = 3'd4,
      ST_PRE  = 3'd5,
      ST_REF  = 3'd6
   } dram_state_t;

   // Width of the shared timing down-counter (timings are 1..15 cycles).
   localparam int TCNT_W = 4;

   // Default timings in clk cycles.
   localparam int c_t_ras_mux    = 2;
   localparam int c_t_mux_cas    = 2;
   localparam int c_t_cas        = 4;
   localparam int c_t_pre        = 3;
   localparam int c_t_ref        = 6;
   localparam int c_ref_interval = 1500;

   // Counter load value for a phase lasting 'cycles' clocks (exit at zero).
   function automatic logic [TCNT_W-1:0] tcnt_load(input int cycles);
      return TCNT_W'(cycles - 1);
   endfunction

   // Active-low one-hot strobe for the selected bank.
   function automatic logic [3:0] bank_strobe_n(input logic [1:0] bank);
      logic [3:0] strobe;
      strobe       = 4'hF;
      strobe[bank] = 1'b0;
      return strobe;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dram_refresh_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dram_refresh_timer                                        |
// | Purpose  : Periodic refresh tick, pending-refresh flag and sticky    |
// |            overrun flag. Only built when DRAM_AUTO_REFRESH_EN is     |
// |            defined.                                                  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`ifdef DRAM_AUTO_REFRESH_EN
module dram_refresh_timer
   import dram_pkg::*;
#(
   parameter int REF_INTERVAL = c_ref_interval
) (
   input  logic clk,
   input  logic reset_n,
   input  logic refresh_req,
   input  logic ref_take,
   output logic ref_want,
   output logic refresh_overrun
);

   localparam logic [15:0] c_last = 16'(REF_INTERVAL - 1);

   logic [15:0] r_int_cnt;
   logic        r_ref_pend;
   logic        w_tick;

   assign w_tick   = (r_int_cnt == c_last);
   // A fresh request counts in the same cycle it arrives so IDLE can act on it.
   assign ref_want = r_ref_pend | refresh_req | w_tick;

   // Free-running interval counter, one tick every REF_INTERVAL cycles.
   always_ff @(posedge clk) begin
      if (!reset_n)    r_int_cnt <= '0;
      else if (w_tick) r_int_cnt <= '0;
      else             r_int_cnt <= r_int_cnt + 16'd1;
   end

   // Pending flag: merged requests, cleared when the sequencer starts a refresh.
   always_ff @(posedge clk) begin
      if (!reset_n)                    r_ref_pend <= 1'b0;
      else if (ref_take)               r_ref_pend <= 1'b0;
      else if (refresh_req || w_tick)  r_ref_pend <= 1'b1;
   end

   // Sticky overrun: a tick landed while a refresh was still outstanding.
   always_ff @(posedge clk) begin
      if (!reset_n)                  refresh_overrun <= 1'b0;
      else if (w_tick && r_ref_pend) refresh_overrun <= 1'b1;
   end

endmodule
`endif
`default_nettype wire

// File: rtl/dram_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dram_sequencer                                            |
// | Purpose  : Cycle-accurate RAS/CAS/address-mux sequencer for four     |
// |            DRAM banks, arbitrating bus accesses against RAS-only     |
// |            refresh. Define DRAM_AUTO_REFRESH_EN for the internal     |
// |            refresh interval timer and refresh_overrun output.        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module dram_sequencer
   import dram_pkg::*;
#(
   parameter int T_RAS_MUX = c_t_ras_mux,
   parameter int T_MUX_CAS = c_t_mux_cas,
   parameter int T_CAS     = c_t_cas,
   parameter int T_PRE     = c_t_pre,
   parameter int T_REF     = c_t_ref
`ifdef DRAM_AUTO_REFRESH_EN
   ,
   parameter int REF_INTERVAL = c_ref_interval
`endif
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req,
   input  logic       we,
   input  logic       ram_sel,
   input  logic [1:0] bank,
   input  logic       refresh_req,
   output logic [3:0] ras_n,
   output logic [3:0] cas_n,
   output logic       addr_sel,
   output logic       we_n,
   output logic       done,
   output logic       busy,
   output logic       refresh_ack
`ifdef DRAM_AUTO_REFRESH_EN
   ,
   output logic       refresh_overrun
`endif
);

   dram_state_t       r_state;
   dram_state_t       w_next_state;
   logic [TCNT_W-1:0] r_cnt;
   logic [TCNT_W-1:0] w_cnt_next;
   logic [1:0]        r_bank;
   logic              r_we;
   logic              w_accept;
   logic              w_ref_take;
   logic              w_ref_want;
   logic [3:0]        w_strobe_n;

   assign w_strobe_n = bank_strobe_n(r_bank);

`ifdef DRAM_AUTO_REFRESH_EN
   dram_refresh_timer #(
      .REF_INTERVAL (REF_INTERVAL)
   ) u_refresh_timer (
      .clk             (clk),
      .reset_n         (reset_n),
      .refresh_req     (refresh_req),
      .ref_take        (w_ref_take),
      .ref_want        (w_ref_want),
      .refresh_overrun (refresh_overrun)
   );
`else
   logic r_ref_pend;

   assign w_ref_want = r_ref_pend | refresh_req;

   // Pending refresh: external pulses merge until IDLE starts the refresh.
   always_ff @(posedge clk) begin
      if (!reset_n)         r_ref_pend <= 1'b0;
      else if (w_ref_take)  r_ref_pend <= 1'b0;
      else if (refresh_req) r_ref_pend <= 1'b1;
   end
`endif

   // State, shared timing counter and latched access attributes.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_bank  <= 2'd0;
         r_we    <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_cnt_next;
         if (w_accept) begin
            r_bank <= bank;
            r_we   <= we;
         end
      end
   end

   // Next state and counter reload; the counter is reloaded on every state entry.
   always_comb begin
      w_next_state = r_state;
      w_cnt_next   = r_cnt;
      w_accept     = 1'b0;
      w_ref_take   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_ref_want) begin
               w_next_state = ST_REF;
               w_cnt_next   = tcnt_load(T_REF);
               w_ref_take   = 1'b1;
            end else if (req && ram_sel) begin
               w_next_state = ST_RAS;
               w_cnt_next   = tcnt_load(T_RAS_MUX);
               w_accept     = 1'b1;
            end
         end
         ST_RAS: begin
            if (r_cnt == '0) begin
               w_next_state = ST_MUX;
               w_cnt_next   = tcnt_load(T_MUX_CAS);
            end else begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end
         ST_MUX: begin
            if (r_cnt == '0) begin
               w_next_state = ST_CAS;
               w_cnt_next   = tcnt_load(T_CAS);
            end else begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end
         ST_CAS: begin
            if (r_cnt == '0) begin
               // A count of one marks the first HOLD cycle, which raises done.
               w_next_state = ST_HOLD;
               w_cnt_next   = TCNT_W'(1);
            end else begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end
         ST_HOLD: begin
            if (!req) begin
               w_next_state = ST_PRE;
               w_cnt_next   = tcnt_load(T_PRE);
            end else if (r_cnt != '0) begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end
         ST_PRE: begin
            if (r_cnt == '0) begin
               w_next_state = ST_IDLE;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end
         ST_REF: begin
            if (r_cnt == '0) begin
               w_next_state = ST_PRE;
               w_cnt_next   = tcnt_load(T_PRE);
            end else begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   // Registered DRAM strobes and status, decoded from the current state.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ras_n       <= 4'hF;
         cas_n       <= 4'hF;
         addr_sel    <= 1'b0;
         we_n        <= 1'b1;
         done        <= 1'b0;
         busy        <= 1'b0;
         refresh_ack <= 1'b0;
      end else begin
         ras_n       <= 4'hF;
         cas_n       <= 4'hF;
         addr_sel    <= 1'b0;
         we_n        <= 1'b1;
         done        <= 1'b0;
         refresh_ack <= 1'b0;
         busy        <= (r_state != ST_IDLE);
         case (r_state)
            ST_RAS: begin
               ras_n <= w_strobe_n;
            end
            ST_MUX: begin
               ras_n    <= w_strobe_n;
               addr_sel <= 1'b1;
            end
            ST_CAS, ST_HOLD: begin
               ras_n    <= w_strobe_n;
               cas_n    <= w_strobe_n;
               addr_sel <= 1'b1;
               we_n     <= ~r_we;
               done     <= (r_state == ST_HOLD) && (r_cnt != '0);
            end
            ST_REF: begin
               ras_n       <= 4'h0;
               refresh_ack <= (r_cnt == '0);
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dram_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_dram_sequencer                                         |
// | Purpose  : Self-checking bench for dram_sequencer: directed scenarios|
// |            plus randomized traffic against a cycle-schedule model.   |
// |            DRAM_AUTO_REFRESH_EN adds the refresh timer checks.       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_dram_sequencer;

   localparam int TRM = 2, TMC = 2, TC = 4, TP = 3, TR = 6;
   localparam int RI  = 1500;

   // Expected output record for one cycle; 'hold' marks the HOLD phase.
   typedef struct packed {
      logic [3:0] ras_n;
      logic [3:0] cas_n;
      logic       addr_sel;
      logic       we_n;
      logic       done;
      logic       busy;
      logic       ack;
      logic       hold;
   } rec_t;

   logic       clk, reset_n, req, we, ram_sel, refresh_req;
   logic [1:0] bank;
   logic [3:0] ras_n, cas_n;
   logic       addr_sel, we_n, done, busy, refresh_ack;
   logic [12:0] w_obs;

   int cmp_count  = 0;
   int fail_count = 0;

   assign w_obs = {ras_n, cas_n, addr_sel, we_n, done, busy, refresh_ack};

`ifdef DRAM_AUTO_REFRESH_EN
   logic       refresh_overrun;
   logic       t2_reset_n, t2_req;
   logic [3:0] t2_ras_n, t2_cas_n;
   logic       t2_addr_sel, t2_we_n, t2_done, t2_busy, t2_ack, t2_ovr;
`endif

   dram_sequencer u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req         (req),
      .we          (we),
      .ram_sel     (ram_sel),
      .bank        (bank),
      .refresh_req (refresh_req),
      .ras_n       (ras_n),
      .cas_n       (cas_n),
      .addr_sel    (addr_sel),
      .we_n        (we_n),
      .done        (done),
      .busy        (busy),
      .refresh_ack (refresh_ack)
`ifdef DRAM_AUTO_REFRESH_EN
      ,
      .refresh_overrun (refresh_overrun)
`endif
   );

`ifdef DRAM_AUTO_REFRESH_EN
   dram_sequencer #(.REF_INTERVAL(20)) u_dut_ovr (
      .clk             (clk),
      .reset_n         (t2_reset_n),
      .req             (t2_req),
      .we              (1'b0),
      .ram_sel         (1'b1),
      .bank            (2'd1),
      .refresh_req     (1'b0),
      .ras_n           (t2_ras_n),
      .cas_n           (t2_cas_n),
      .addr_sel        (t2_addr_sel),
      .we_n            (t2_we_n),
      .done            (t2_done),
      .busy            (t2_busy),
      .refresh_ack     (t2_ack),
      .refresh_overrun (t2_ovr)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   rec_t q[$];
   rec_t act, exp_rec;
   bit   pend;
   bit   exp_ovr;
   int   mcnt;

   function automatic rec_t mk(logic [3:0] r, logic [3:0] c, logic a, logic w,
                               logic d, logic b, logic k, logic h);
      rec_t x;
      x.ras_n = r; x.cas_n = c; x.addr_sel = a; x.we_n = w;
      x.done = d; x.busy = b; x.ack = k; x.hold = h;
      return x;
   endfunction

   function automatic rec_t idle_rec();
      return mk(4'hF, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic void push_n(rec_t r, int n);
      for (int i = 0; i < n; i++) q.push_back(r);
   endfunction

   // Model: each cycle's activity is scheduled up front; outputs show it one cycle later.
   always @(posedge clk) begin : model
      logic [3:0] rs;
      bit want, tick;
      exp_rec = act;
      if (!reset_n) begin
         q.delete();
         pend = 0; mcnt = 0; exp_ovr = 0;
         act = idle_rec();
         exp_rec = idle_rec();
      end else begin
         tick = 0;
`ifdef DRAM_AUTO_REFRESH_EN
         tick = (mcnt == RI - 1);
         if (tick && pend) exp_ovr = 1;
         mcnt = tick ? 0 : mcnt + 1;
`endif
         if (!act.busy) begin
            want = pend || refresh_req || tick;
            if (want) begin
               pend = 0;
               push_n(mk(4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), TR - 1);
               push_n(mk(4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0), 1);
               push_n(mk(4'hF, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), TP);
            end else if (req && ram_sel) begin
               rs = 4'hF;
               rs[bank] = 1'b0;
               push_n(mk(rs, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), TRM);
               push_n(mk(rs, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), TMC);
               push_n(mk(rs, rs, 1'b1, ~we, 1'b0, 1'b1, 1'b0, 1'b0), TC);
               push_n(mk(rs, rs, 1'b1, ~we, 1'b1, 1'b1, 1'b0, 1'b1), 1);
               push_n(mk(4'hF, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), TP);
            end
         end else if (refresh_req || tick) begin
            pend = 1;
         end
         if (act.hold && req) act.done = 1'b0;
         else if (q.size() > 0) act = q.pop_front();
         else act = idle_rec();
      end
   end

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      cmp_count++;
      if (w_obs !== 13'b1111_1111_0_1_0_0_0) begin
         fail_count++;
         $display("FAIL reset_values got %h want %h", w_obs, 13'b1111_1111_0_1_0_0_0);
      end
      reset_n = 1'b1;
      @(negedge clk);
      cmp_count++;
      if (w_obs !== exp_rec[13:1]) begin
         fail_count++;
         $display("FAIL reset_idle got %h want %h", w_obs, exp_rec[13:1]);
      end
   endtask

   task automatic test_read_bank2();
      @(negedge clk);
      req = 1'b1; ram_sel = 1'b1; we = 1'b0; bank = 2'd2;
      for (int k = 0; k <= 15; k++) begin
         @(negedge clk);
         cmp_count++;
         if (w_obs !== exp_rec[13:1]) begin
            fail_count++;
            $display("FAIL read_model k=%0d got %h want %h", k, w_obs, exp_rec[13:1]);
         end
         if (k == 1) begin
            cmp_count++;
            if (ras_n !== 4'b1011) begin
               fail_count++; $display("FAIL read_ras k=1 got %b want 1011", ras_n);
            end
         end
         if (k == 2 || k == 3) begin
            cmp_count++;
            if (addr_sel !== (k == 3)) begin
               fail_count++; $display("FAIL read_addr_sel k=%0d got %b want %b", k, addr_sel, k == 3);
            end
         end
         if (k == 4 || k == 5) begin
            cmp_count++;
            if (cas_n !== ((k == 5) ? 4'b1011 : 4'hF)) begin
               fail_count++; $display("FAIL read_cas k=%0d got %b", k, cas_n);
            end
         end
         cmp_count++;
         if (done !== (k == 9)) begin
            fail_count++; $display("FAIL read_done k=%0d got %b want %b", k, done, k == 9);
         end
         if (k >= 11 && k <= 13) begin
            cmp_count++;
            if ({ras_n, cas_n, busy} !== 9'h1FF) begin
               fail_count++; $display("FAIL read_pre k=%0d got %h want 1ff", k, {ras_n, cas_n, busy});
            end
         end
         if (k == 14) begin
            cmp_count++;
            if (busy !== 1'b0) begin
               fail_count++; $display("FAIL read_idle busy got %b want 0", busy);
            end
         end
         if (k == 9) req = 1'b0;
      end
   endtask

   task automatic test_write_bank0();
      @(negedge clk);
      req = 1'b1; ram_sel = 1'b1; we = 1'b1; bank = 2'd0;
      for (int k = 0; k <= 15; k++) begin
         @(negedge clk);
         cmp_count++;
         if (w_obs !== exp_rec[13:1]) begin
            fail_count++;
            $display("FAIL write_model k=%0d got %h want %h", k, w_obs, exp_rec[13:1]);
         end
         cmp_count++;
         if (we_n !== cas_n[0] || ras_n[3:1] !== 3'b111) begin
            fail_count++;
            $display("FAIL write_strobes k=%0d got we_n=%b cas_n=%b ras_n=%b", k, we_n, cas_n, ras_n);
         end
         if (k == 2) begin we = 1'b0; bank = 2'd3; end
         if (done) req = 1'b0;
      end
      we = 1'b0;
   endtask

   task automatic test_ram_sel_off();
      @(negedge clk);
      req = 1'b1; ram_sel = 1'b0; bank = 2'd1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         cmp_count++;
         if ({busy, ras_n, cas_n} !== 9'h0FF || w_obs !== exp_rec[13:1]) begin
            fail_count++;
            $display("FAIL ramsel_off k=%0d got %h want %h", k, w_obs, exp_rec[13:1]);
         end
      end
      req = 1'b0; ram_sel = 1'b1;
   endtask

   task automatic test_refresh_collision();
      int acks, ras_low, first_acc;
      acks = 0; ras_low = 0; first_acc = -1;
      @(negedge clk);
      req = 1'b1; ram_sel = 1'b1; we = 1'b0; bank = 2'd1; refresh_req = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         refresh_req = 1'b0;
         cmp_count++;
         if (w_obs !== exp_rec[13:1]) begin
            fail_count++;
            $display("FAIL collide_model k=%0d got %h want %h", k, w_obs, exp_rec[13:1]);
         end
         if (refresh_ack) acks++;
         if (ras_n == 4'h0) ras_low++;
         if (ras_n == 4'b1101 && first_acc < 0) first_acc = k;
         if (done) req = 1'b0;
      end
      cmp_count++;
      if (acks != 1 || ras_low != TR || first_acc != 1 + TR + TP + 1) begin
         fail_count++;
         $display("FAIL collide_order got ack=%0d ras_low=%0d acc=%0d want 1 %0d %0d",
                  acks, ras_low, first_acc, TR, 1 + TR + TP + 1);
      end
   endtask

   task automatic test_refresh_during_cas();
      int first_ref;
      first_ref = -1;
      @(negedge clk);
      req = 1'b1; ram_sel = 1'b1; we = 1'b0; bank = 2'd3;
      for (int k = 0; k <= 26; k++) begin
         @(negedge clk);
         refresh_req = (k == 5);
         cmp_count++;
         if (w_obs !== exp_rec[13:1]) begin
            fail_count++;
            $display("FAIL cas_ref_model k=%0d got %h want %h", k, w_obs, exp_rec[13:1]);
         end
         if (k == 9) begin
            cmp_count++;
            if (done !== 1'b1) begin
               fail_count++; $display("FAIL cas_ref_done got %b want 1", done);
            end
            req = 1'b0;
         end
         if (ras_n == 4'h0 && first_ref < 0) first_ref = k;
      end
      cmp_count++;
      if (first_ref != 15) begin
         fail_count++; $display("FAIL cas_ref_start got %0d want 15", first_ref);
      end
   endtask

   task automatic test_reset_in_mux();
      @(negedge clk);
      req = 1'b1; ram_sel = 1'b1; we = 1'b1; bank = 2'd2;
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk);
         cmp_count++;
         if (w_obs !== exp_rec[13:1]) begin
            fail_count++;
            $display("FAIL mux_reset_model k=%0d got %h want %h", k, w_obs, exp_rec[13:1]);
         end
         if (k == 3) begin
            cmp_count++;
            if (w_obs !== 13'b1111_1111_0_1_0_0_0) begin
               fail_count++;
               $display("FAIL mux_reset_values got %h want %h", w_obs, 13'b1111_1111_0_1_0_0_0);
            end
            reset_n = 1'b1;
         end
         if (k == 2) begin reset_n = 1'b0; req = 1'b0; end
      end
      we = 1'b0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 800; k++) begin
         @(negedge clk);
         cmp_count++;
         if (w_obs !== exp_rec[13:1]) begin
            fail_count++;
            $display("FAIL random_model k=%0d got %h want %h", k, w_obs, exp_rec[13:1]);
         end
`ifdef DRAM_AUTO_REFRESH_EN
         cmp_count++;
         if (refresh_overrun !== exp_ovr) begin
            fail_count++;
            $display("FAIL random_overrun k=%0d got %b want %b", k, refresh_overrun, exp_ovr);
         end
`endif
         refresh_req = ($urandom_range(0, 24) == 0);
         if (req) begin
            if (done || $urandom_range(0, 39) == 0) req = 1'b0;
            else if ($urandom_range(0, 7) == 0) begin
               bank = 2'($urandom_range(0, 3));
               we   = 1'($urandom_range(0, 1));
            end
         end else if ($urandom_range(0, 3) == 0) begin
            req     = 1'b1;
            we      = 1'($urandom_range(0, 1));
            bank    = 2'($urandom_range(0, 3));
            ram_sel = ($urandom_range(0, 5) != 0);
         end
         reset_n = ($urandom_range(0, 199) != 0);
      end
      req = 1'b0; refresh_req = 1'b0; reset_n = 1'b1;
   endtask

`ifdef DRAM_AUTO_REFRESH_EN
   task automatic test_overrun();
      @(negedge clk);
      t2_reset_n = 1'b0;
      repeat (2) @(negedge clk);
      cmp_count++;
      if (t2_ovr !== 1'b0) begin
         fail_count++; $display("FAIL overrun_reset got %b want 0", t2_ovr);
      end
      t2_reset_n = 1'b1; t2_req = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (k == 30) begin
            cmp_count++;
            if (t2_ovr !== 1'b0) begin
               fail_count++; $display("FAIL overrun_early got %b want 0", t2_ovr);
            end
         end
         if (k == 45) begin
            cmp_count++;
            if (t2_ovr !== 1'b1) begin
               fail_count++; $display("FAIL overrun_set got %b want 1", t2_ovr);
            end
         end
      end
      t2_req = 1'b0; t2_reset_n = 1'b0;
      @(negedge clk);
      cmp_count++;
      if (t2_ovr !== 1'b0) begin
         fail_count++; $display("FAIL overrun_clear got %b want 0", t2_ovr);
      end
   endtask
`endif

   initial begin
      reset_n = 1'b0; req = 1'b0; we = 1'b0; ram_sel = 1'b1; bank = 2'd0; refresh_req = 1'b0;
`ifdef DRAM_AUTO_REFRESH_EN
      t2_reset_n = 1'b0; t2_req = 1'b0;
`endif
      test_reset();
      test_read_bank2();
      test_write_bank0();
      test_ram_sel_off();
      test_refresh_collision();
      test_refresh_during_cas();
      test_reset_in_mux();
      test_random();
`ifdef DRAM_AUTO_REFRESH_EN
      test_overrun();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
      $finish;
   end

endmodule
`default_nettype wire
